// File: rtl/riscv_pkg.sv
// Shared opcode/funct7 constants and the multi-cycle control state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXECUTE,
    MEMORY,
    WRITEBACK,
    TRAP
  } ctrlState_t;

endpackage

// File: rtl/main_decoder.sv
// Classifies opcode/funct7 into instruction class flags, ALU controls and an illegal flag.
// Latency: purely combinational.
// Backpressure: none.
module main_decoder
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [6:0] funct7,
  output logic       isLoad,
  output logic       isStore,
  output logic       isBranch,
  output logic       useImm,
  output logic       subtract,
  output logic       illegal
);

  always_comb begin
    isLoad   = 1'b0;
    isStore  = 1'b0;
    isBranch = 1'b0;
    useImm   = 1'b0;
    subtract = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OPC_LOAD: begin
        isLoad = 1'b1;
        useImm = 1'b1;
      end
      OPC_STORE: begin
        isStore = 1'b1;
        useImm  = 1'b1;
      end
      OPC_OPIMM: useImm = 1'b1;
      OPC_BRANCH: begin
        isBranch = 1'b1;
        subtract = 1'b1;
      end
      OPC_OP: begin
        if (funct7 == F7_ALT)       subtract = 1'b1;
        else if (funct7 != F7_BASE) illegal  = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle Moore control unit + PC: fetch, decode, execute, memory, writeback.
// Latency: BRANCH 3, OP/OP-IMM/STORE 4, LOAD 5 cycles with zero-wait handshakes.
// Backpressure: fetchRequest/dataRequest held until fetchValid/dataReady; each wait adds one cycle.
module multicycle_control
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] PC_RESET = '0,
  parameter int              CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic             fetchRequest,
  input  logic             fetchValid,
  input  logic [31:0]      fetchData,
  output logic             dataRequest,
  input  logic             dataReady,
  input  logic [XLEN-1:0]  immediate,
  input  logic             selectedFlag,
  output logic [31:0]      instruction,
  output logic [XLEN-1:0]  pc,
  output logic             writeEnable_Registers,
  output logic             writeEnable_DataMemory,
  output logic             muxSelect_ImmVsDataout2,
  output logic             muxSelect_SumVsReadData,
  output logic             SumOrSub,
  output logic             trap,
  output logic [CNT_W-1:0] retired
);

  ctrlState_t      state, stateNext;
  logic            isLoad, isStore, isBranch, useImm, subtract, illegal;
  logic            loadIr, retire;
  logic [XLEN-1:0] pcNext;

  main_decoder uDecoder (
    .opcode   (instruction[6:0]),
    .funct7   (instruction[31:25]),
    .isLoad   (isLoad),
    .isStore  (isStore),
    .isBranch (isBranch),
    .useImm   (useImm),
    .subtract (subtract),
    .illegal  (illegal)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= FETCH;
      pc          <= PC_RESET;
      instruction <= '0;
      retired     <= '0;
    end else begin
      state <= stateNext;
      if (loadIr) instruction <= fetchData;
      if (retire) begin
        pc      <= pcNext;
        retired <= retired + CNT_W'(1);
      end
    end
  end

  always_comb begin
    stateNext               = state;
    loadIr                  = 1'b0;
    retire                  = 1'b0;
    pcNext                  = pc + XLEN'(4);
    fetchRequest            = 1'b0;
    dataRequest             = 1'b0;
    writeEnable_Registers   = 1'b0;
    writeEnable_DataMemory  = 1'b0;
    muxSelect_ImmVsDataout2 = 1'b0;
    muxSelect_SumVsReadData = 1'b0;
    SumOrSub                = 1'b0;
    trap                    = 1'b0;
    case (state)
      FETCH: begin
        // Reset parks the FSM in FETCH; keep the request quiet while reset is held.
        fetchRequest = reset_n;
        if (fetchValid) begin
          loadIr    = 1'b1;
          stateNext = DECODE;
        end
      end
      DECODE: stateNext = illegal ? TRAP : EXECUTE;
      EXECUTE: begin
        muxSelect_ImmVsDataout2 = useImm;
        SumOrSub                = subtract;
        if (isBranch) begin
          retire    = 1'b1;
          stateNext = FETCH;
          if (selectedFlag) pcNext = pc + immediate;
        end else if (isLoad || isStore) begin
          stateNext = MEMORY;
        end else begin
          stateNext = WRITEBACK;
        end
      end
      MEMORY: begin
        muxSelect_ImmVsDataout2 = useImm;
        SumOrSub                = subtract;
        dataRequest             = 1'b1;
        writeEnable_DataMemory  = isStore;
        if (dataReady) begin
          if (isStore) begin
            retire    = 1'b1;
            stateNext = FETCH;
          end else begin
            stateNext = WRITEBACK;
          end
        end
      end
      WRITEBACK: begin
        muxSelect_ImmVsDataout2 = useImm;
        SumOrSub                = subtract;
        writeEnable_Registers   = (instruction[11:7] != 5'd0);
        muxSelect_SumVsReadData = isLoad;
        retire                  = 1'b1;
        stateNext               = FETCH;
      end
      TRAP: trap = 1'b1;
      default: stateNext = FETCH;
    endcase
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Parametrised multi-cycle control unit and program counter for the RISC-V datapath. It replaces the externally driven control inputs of the current top level. It fetches instructions through a request/valid handshake, latches them in an internal instruction register, and sequences each one through a Moore state machine. Per state it drives the datapath's register-file, data-memory, mux and add/sub controls, and it updates the PC for sequential flow and branches.

## Interface
Parameters:
- XLEN, 64, PC and immediate width
- PC_RESET, 0, PC value after reset
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- fetchRequest  out  1  instruction fetch request at address pc
- fetchValid  in  1  fetchData valid; completes the fetch handshake
- fetchData  in  32  fetched instruction word
- dataRequest  out  1  data-memory access request
- dataReady  in  1  data-memory access complete
- immediate  in  XLEN  sign-extended immediate from the instruction setter
- selectedFlag  in  1  branch condition from the datapath (valid in EXECUTE)
- instruction  out  32  instruction register, sliced by the datapath for rs1/rs2/rd/funct3
- pc  out  XLEN  program counter
- writeEnable_Registers  out  1  register-file write enable
- writeEnable_DataMemory  out  1  data-memory write enable
- muxSelect_ImmVsDataout2  out  1  1 = immediate, 0 = dataout2
- muxSelect_SumVsReadData  out  1  1 = memory read data, 0 = ALU sum
- SumOrSub  out  1  1 = subtract
- trap  out  1  sticky illegal-instruction flag
- retired  out  CNT_W  retired-instruction count, wraps modulo 2^CNT_W

## Operation
- States: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP.
- FETCH:
  - fetchRequest=1 and held until fetchValid.
  - On fetchValid, instruction<=fetchData and the FSM goes to DECODE.
- DECODE:
  - Classifies opcode as LOAD 0000011, STORE 0100011, OP 0110011, OP-IMM 0010011 or BRANCH 1100011.
  - Any other opcode goes to TRAP.
  - OP with funct7 other than 0000000/0100000 also goes to TRAP.
- EXECUTE drives the ALU controls:
  - muxSelect_ImmVsDataout2=1 for LOAD, STORE and OP-IMM; 0 otherwise.
  - SumOrSub=1 for BRANCH, and for OP with funct7=0100000.
  - Next state: OP and OP-IMM go to WRITEBACK; LOAD and STORE go to MEMORY.
  - BRANCH: pc<=pc+immediate if selectedFlag, else pc+4; retired increments; next state FETCH.
- MEMORY:
  - dataRequest=1; for STORE, writeEnable_DataMemory=1 as well; both held until dataReady.
  - On dataReady, LOAD goes to WRITEBACK.
  - On dataReady, STORE does pc<=pc+4, retired++, and goes to FETCH.
- WRITEBACK:
  - writeEnable_Registers=1 for exactly one cycle, forced to 0 when rd (instruction[11:7]) is 0.
  - muxSelect_SumVsReadData=1 for LOAD.
  - pc<=pc+4, retired++, next state FETCH.
- TRAP:
  - All enables and requests are 0 and trap=1.
  - pc, instruction and retired are frozen.
  - Left only by reset.
- ALU controls hold their EXECUTE values through MEMORY and WRITEBACK so the datapath result stays stable.
- PC arithmetic is modulo 2^XLEN, so wrap-around is silent. immediate is added as two's complement.

## Timing
- Outputs are Moore:
  - decoded from state and the instruction register only;
  - no combinational path from any input to any output.
- Reset:
  - state=FETCH, pc=PC_RESET, instruction=0, retired=0, trap=0;
  - all enables, requests and mux selects are 0.
- Latency with zero-wait handshakes (fetchValid/dataReady high in the first request cycle):
  - BRANCH: 3 cycles
  - OP, OP-IMM and STORE: 4 cycles
  - LOAD: 5 cycles
- Each wait cycle on fetchValid or dataReady adds exactly one cycle.
- fetchValid/dataReady are ignored outside FETCH/MEMORY.
- fetchValid and dataReady high together are harmless: only the one relevant to the current state acts.
- Reset asserted mid-instruction:
  - outputs return to their reset values asynchronously;
  - the pending memory write is aborted and no register write occurs.
- retired increments on the same edge as the final pc update.

## Structure
- Shared package riscv_pkg holds:
  - opcode constants (OPC_LOAD, OPC_STORE, OPC_OP, OPC_OPIMM, OPC_BRANCH);
  - funct7 constants;
  - the control state enum.
- Sub-module main_decoder, purely combinational:
  - maps opcode/funct7 to an instruction class plus an illegal flag;
  - multicycle_control instantiates it once in DECODE/EXECUTE logic.

## Test plan
- Reset with PC_RESET=0x100, then fetch add x3,x1,x2 (0x002081B3) with fetchValid after 2 wait cycles:
  - writeEnable_Registers pulses on cycle 6;
  - pc becomes 0x104; retired=1; SumOrSub=0.
- sub x3,x1,x2 (0x402081B3):
  - SumOrSub=1 and muxSelect_ImmVsDataout2=0 in EXECUTE and WRITEBACK.
- sw, with dataReady delayed 3 cycles:
  - writeEnable_DataMemory held high 4 cycles;
  - no register write; pc+=4.
- lw:
  - muxSelect_SumVsReadData=1 during the WRITEBACK pulse.
- lw with rd=0:
  - writeEnable_Registers stays 0; retired still increments.
- beq with immediate=-8:
  - selectedFlag=1 gives pc 0x110->0x108;
  - selectedFlag=0 gives 0x114;
  - 3 cycles each.
- Opcode 0x0000007F:
  - trap=1 and stays set, fetchRequest=0 for 20 cycles.
  - Reset_n low mid-MEMORY of a store: writeEnable_DataMemory drops immediately, pc=PC_RESET.
  - Separately, pc=2^XLEN-4 followed by an add wraps pc to 0.
